// File: rtl/decode.sv
// RV32I first decode stage (de0 -> de1): one raw instruction in, one registered micro-op out.
// The instr package carries the instruction/micro-op layouts and is shared with rename/execute.
package instr;

  typedef enum logic [6:0] {
    OP_LOAD     = 7'b0000011,
    OP_MISC_MEM = 7'b0001111,
    OP_ALU_I    = 7'b0010011,
    OP_AUIPC    = 7'b0010111,
    OP_STORE    = 7'b0100011,
    OP_ALU_R    = 7'b0110011,
    OP_LUI      = 7'b0110111,
    OP_BRANCH   = 7'b1100011,
    OP_JALR     = 7'b1100111,
    OP_JAL      = 7'b1101111,
    OP_SYSTEM   = 7'b1110011
  } t_opcode;

  typedef enum logic [5:0] {
    UOP_ADD, UOP_SUB, UOP_SLL, UOP_SLT, UOP_SLTU, UOP_XOR, UOP_SRL, UOP_SRA, UOP_OR, UOP_AND,
    UOP_LUI, UOP_AUIPC, UOP_JAL, UOP_JALR, UOP_BR,
    UOP_LD, UOP_ST,
    UOP_FENCE, UOP_SYSTEM,
    UOP_ILLEGAL
  } t_uop;

  typedef struct packed {
    logic [6:0] funct7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [6:0] opcode;
  } t_rv_instr;

  typedef struct packed {
    logic        valid;
    logic        illegal;
    t_uop        uop;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        rd_we;
    logic        rs1_re;
    logic        rs2_re;
    logic [31:0] imm;
  } t_uinstr;

endpackage

module decode
  import instr::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      valid_de0,
  input  t_rv_instr instr_de0,
  output t_uinstr   uinstr_de1
);

  // alt selects the funct7=0100000 variant (SUB/SRA); callers only set it for funct3 0 or 5.
  function automatic t_uop alu_uop(input logic [2:0] f3, input logic alt);
    case (f3)
      3'd0:    alu_uop = alt ? UOP_SUB : UOP_ADD;
      3'd1:    alu_uop = UOP_SLL;
      3'd2:    alu_uop = UOP_SLT;
      3'd3:    alu_uop = UOP_SLTU;
      3'd4:    alu_uop = UOP_XOR;
      3'd5:    alu_uop = alt ? UOP_SRA : UOP_SRL;
      3'd6:    alu_uop = UOP_OR;
      default: alu_uop = UOP_AND;
    endcase
  endfunction

  logic [31:0] raw;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_u;
  logic [31:0] imm_j;
  logic        ill;
  logic        f7_zero;
  logic        f7_alt;
  t_uinstr     dec;

  assign raw     = instr_de0;
  assign imm_i   = {{20{raw[31]}}, raw[31:20]};
  assign imm_s   = {{20{raw[31]}}, raw[31:25], raw[11:7]};
  assign imm_b   = {{19{raw[31]}}, raw[31], raw[7], raw[30:25], raw[11:8], 1'b0};
  assign imm_u   = {raw[31:12], 12'b0};
  assign imm_j   = {{11{raw[31]}}, raw[31], raw[19:12], raw[20], raw[30:21], 1'b0};
  assign f7_zero = (instr_de0.funct7 == 7'b0000000);
  assign f7_alt  = (instr_de0.funct7 == 7'b0100000);

  always_comb begin
    dec        = '0;
    dec.valid  = 1'b1;
    dec.funct3 = instr_de0.funct3;
    dec.rd     = instr_de0.rd;
    dec.rs1    = instr_de0.rs1;
    dec.rs2    = instr_de0.rs2;
    dec.uop    = UOP_ILLEGAL;
    ill        = 1'b0;

    case (instr_de0.opcode)
      OP_ALU_R: begin
        dec.rd_we  = 1'b1;
        dec.rs1_re = 1'b1;
        dec.rs2_re = 1'b1;
        if (f7_zero)
          dec.uop = alu_uop(instr_de0.funct3, 1'b0);
        else if (f7_alt && (instr_de0.funct3 == 3'd0 || instr_de0.funct3 == 3'd5))
          dec.uop = alu_uop(instr_de0.funct3, 1'b1);
        else
          ill = 1'b1;
      end
      OP_ALU_I: begin
        dec.rd_we  = 1'b1;
        dec.rs1_re = 1'b1;
        dec.imm    = imm_i;
        // Shift-immediates reuse funct7 as a qualifier; other ALU-I ops treat it as immediate.
        case (instr_de0.funct3)
          3'd1:    if (f7_zero) dec.uop = UOP_SLL; else ill = 1'b1;
          3'd5: begin
            if (f7_zero)     dec.uop = UOP_SRL;
            else if (f7_alt) dec.uop = UOP_SRA;
            else             ill = 1'b1;
          end
          default: dec.uop = alu_uop(instr_de0.funct3, 1'b0);
        endcase
      end
      OP_LUI: begin
        dec.uop   = UOP_LUI;
        dec.rd_we = 1'b1;
        dec.imm   = imm_u;
      end
      OP_AUIPC: begin
        dec.uop   = UOP_AUIPC;
        dec.rd_we = 1'b1;
        dec.imm   = imm_u;
      end
      OP_JAL: begin
        dec.uop   = UOP_JAL;
        dec.rd_we = 1'b1;
        dec.imm   = imm_j;
      end
      OP_JALR: begin
        dec.uop    = UOP_JALR;
        dec.rd_we  = 1'b1;
        dec.rs1_re = 1'b1;
        dec.imm    = imm_i;
        ill        = (instr_de0.funct3 != 3'd0);
      end
      OP_BRANCH: begin
        dec.uop    = UOP_BR;
        dec.rs1_re = 1'b1;
        dec.rs2_re = 1'b1;
        dec.imm    = imm_b;
        ill        = (instr_de0.funct3 == 3'd2 || instr_de0.funct3 == 3'd3);
      end
      OP_LOAD: begin
        dec.uop    = UOP_LD;
        dec.rd_we  = 1'b1;
        dec.rs1_re = 1'b1;
        dec.imm    = imm_i;
        ill        = (instr_de0.funct3 == 3'd3 || instr_de0.funct3 > 3'd5);
      end
      OP_STORE: begin
        dec.uop    = UOP_ST;
        dec.rs1_re = 1'b1;
        dec.rs2_re = 1'b1;
        dec.imm    = imm_s;
        ill        = (instr_de0.funct3 > 3'd2);
      end
      OP_MISC_MEM: dec.uop = UOP_FENCE;
      OP_SYSTEM: begin
        dec.uop = UOP_SYSTEM;
        dec.imm = imm_i;
      end
      default: ill = 1'b1;
    endcase

    if (ill) begin
      dec.illegal = 1'b1;
      dec.uop     = UOP_ILLEGAL;
      dec.rd_we   = 1'b0;
      dec.rs1_re  = 1'b0;
      dec.rs2_re  = 1'b0;
      dec.imm     = '0;
    end

    if (instr_de0.rd == 5'd0)
      dec.rd_we = 1'b0;
  end

  // Idle cycles only drop valid; the payload keeps its last decoded value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      uinstr_de1 <= '0;
    else if (valid_de0)
      uinstr_de1 <= dec;
    else
      uinstr_de1.valid <= 1'b0;
  end

endmodule

// File: tb/tb_decode.sv
// Directed bench for the de0 -> de1 decoder with hand-computed micro-ops.
module tb_decode;
  import instr::*;

  logic      clk = 1'b0;
  logic      reset;
  logic      valid_de0;
  t_rv_instr instr_de0;
  t_uinstr   uinstr_de1;

  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;

  decode dut (
    .clk        (clk),
    .reset      (reset),
    .valid_de0  (valid_de0),
    .instr_de0  (instr_de0),
    .uinstr_de1 (uinstr_de1)
  );

  always #5 clk = ~clk;

  // Builds an expected micro-op; rd/rs1/rs2/funct3 are raw field copies.
  function automatic t_uinstr mk(input t_uop uop, input logic [31:0] raw, input logic [31:0] imm,
                                 input logic we, input logic r1, input logic r2, input logic ill);
    t_uinstr u;
    u         = '0;
    u.valid   = 1'b1;
    u.illegal = ill;
    u.uop     = uop;
    u.funct3  = raw[14:12];
    u.rd      = raw[11:7];
    u.rs1     = raw[19:15];
    u.rs2     = raw[24:20];
    u.rd_we   = we;
    u.rs1_re  = r1;
    u.rs2_re  = r2;
    u.imm     = imm;
    return u;
  endfunction

  task automatic step(input logic v, input logic [31:0] i);
    @(negedge clk);
    valid_de0 = v;
    instr_de0 = i;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; valid_de0 = 1'b0; instr_de0 = '0;
    #2;
    n_checks++;
    if (uinstr_de1 !== '0) begin
      n_fails++; $display("FAIL reset_async: got %h expected %h", uinstr_de1, 61'h0);
    end
    step(1'b1, 32'h002081B3);
    n_checks++;
    if (uinstr_de1 !== '0) begin
      n_fails++; $display("FAIL reset_held: got %h expected %h", uinstr_de1, 61'h0);
    end
    @(negedge clk); reset = 1'b0; valid_de0 = 1'b0;
  endtask

  task automatic test_alu;
    logic [31:0] v [6];
    t_uinstr     e [6];
    v[0] = 32'h002081B3; e[0] = mk(UOP_ADD, v[0], 32'h0,        1, 1, 1, 0);
    v[1] = 32'h00000033; e[1] = mk(UOP_ADD, v[1], 32'h0,        0, 1, 1, 0);
    v[2] = 32'h402081B3; e[2] = mk(UOP_SUB, v[2], 32'h0,        1, 1, 1, 0);
    v[3] = 32'hFFF00293; e[3] = mk(UOP_ADD, v[3], 32'hFFFFFFFF, 1, 1, 0, 0);
    v[4] = 32'h4020D193; e[4] = mk(UOP_SRA, v[4], 32'h00000402, 1, 1, 0, 0);
    v[5] = 32'h0020D193; e[5] = mk(UOP_SRL, v[5], 32'h00000002, 1, 1, 0, 0);
    for (int i = 0; i < 6; i++) begin
      step(1'b1, v[i]);
      n_checks++;
      if (uinstr_de1 !== e[i]) begin
        n_fails++; $display("FAIL alu[%0d] %h: got %h expected %h", i, v[i], uinstr_de1, e[i]);
      end
    end
  endtask

  task automatic test_upper_jump;
    logic [31:0] v [4];
    t_uinstr     e [4];
    v[0] = 32'h123450B7; e[0] = mk(UOP_LUI,   v[0], 32'h12345000, 1, 0, 0, 0);
    v[1] = 32'h80000117; e[1] = mk(UOP_AUIPC, v[1], 32'h80000000, 1, 0, 0, 0);
    v[2] = 32'hFFDFF0EF; e[2] = mk(UOP_JAL,   v[2], 32'hFFFFFFFC, 1, 0, 0, 0);
    v[3] = 32'h004100E7; e[3] = mk(UOP_JALR,  v[3], 32'h00000004, 1, 1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, v[i]);
      n_checks++;
      if (uinstr_de1 !== e[i]) begin
        n_fails++; $display("FAIL upper_jump[%0d] %h: got %h expected %h", i, v[i], uinstr_de1, e[i]);
      end
    end
  endtask

  task automatic test_mem_branch;
    logic [31:0] v [5];
    t_uinstr     e [5];
    v[0] = 32'hFE000EE3; e[0] = mk(UOP_BR,     v[0], 32'hFFFFFFFC, 0, 1, 1, 0);
    v[1] = 32'h0020A423; e[1] = mk(UOP_ST,     v[1], 32'h00000008, 0, 1, 1, 0);
    v[2] = 32'h0040A103; e[2] = mk(UOP_LD,     v[2], 32'h00000004, 1, 1, 0, 0);
    v[3] = 32'h0FF0000F; e[3] = mk(UOP_FENCE,  v[3], 32'h0,        0, 0, 0, 0);
    v[4] = 32'h00100073; e[4] = mk(UOP_SYSTEM, v[4], 32'h00000001, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, v[i]);
      n_checks++;
      if (uinstr_de1 !== e[i]) begin
        n_fails++; $display("FAIL mem_branch[%0d] %h: got %h expected %h", i, v[i], uinstr_de1, e[i]);
      end
    end
  endtask

  task automatic test_illegal;
    logic [31:0] v [6];
    v[0] = 32'h0000007F;  // unknown opcode
    v[1] = 32'h02208133;  // OP_ALU_R funct7=1
    v[2] = 32'h00013083;  // LOAD funct3=3
    v[3] = 32'h00002063;  // BRANCH funct3=2
    v[4] = 32'h40009093;  // SLLI funct7!=0
    v[5] = 32'h0000B023;  // STORE funct3=3
    for (int i = 0; i < 6; i++) begin
      t_uinstr e;
      e = mk(UOP_ILLEGAL, v[i], 32'h0, 0, 0, 0, 1);
      step(1'b1, v[i]);
      n_checks++;
      if (uinstr_de1 !== e) begin
        n_fails++; $display("FAIL illegal[%0d] %h: got %h expected %h", i, v[i], uinstr_de1, e);
      end
    end
  endtask

  task automatic test_valid_hold;
    t_uinstr e;
    e = mk(UOP_ADD, 32'h002081B3, 32'h0, 1, 1, 1, 0);
    step(1'b1, 32'h002081B3);
    n_checks++;
    if (uinstr_de1 !== e) begin
      n_fails++; $display("FAIL pulse_valid: got %h expected %h", uinstr_de1, e);
    end
    e.valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 32'h0000007F);
      n_checks++;
      if (uinstr_de1 !== e) begin
        n_fails++; $display("FAIL payload_hold[%0d]: got %h expected %h", i, uinstr_de1, e);
      end
    end
  endtask

  task automatic test_back_to_back;
    t_uinstr e0, e1;
    e0 = mk(UOP_LUI, 32'h123450B7, 32'h12345000, 1, 0, 0, 0);
    e1 = mk(UOP_ILLEGAL, 32'h02208133, 32'h0, 0, 0, 0, 1);
    step(1'b1, 32'h123450B7);
    n_checks++;
    if (uinstr_de1 !== e0) begin
      n_fails++; $display("FAIL b2b_first: got %h expected %h", uinstr_de1, e0);
    end
    step(1'b1, 32'h02208133);
    n_checks++;
    if (uinstr_de1 !== e1) begin
      n_fails++; $display("FAIL b2b_second: got %h expected %h", uinstr_de1, e1);
    end
  endtask

  task automatic test_reset_midrun;
    t_uinstr e;
    step(1'b1, 32'hFFF00293);
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_checks++;
    if (uinstr_de1 !== '0) begin
      n_fails++; $display("FAIL midrun_reset: got %h expected %h", uinstr_de1, 61'h0);
    end
    @(negedge clk);
    reset = 1'b0;
    e = mk(UOP_SUB, 32'h402081B3, 32'h0, 1, 1, 1, 0);
    step(1'b1, 32'h402081B3);
    n_checks++;
    if (uinstr_de1 !== e) begin
      n_fails++; $display("FAIL after_reset: got %h expected %h", uinstr_de1, e);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_upper_jump();
    test_mem_branch();
    test_illegal();
    test_valid_hold();
    test_back_to_back();
    test_reset_midrun();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
